// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding, protection width and clog2 helper for the APB splitter
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int APB_PROT_W = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps an upstream address to a downstream slot index and a hit flag
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int NUM_SLV = 4,
    parameter int SLV_AW  = 8,
    parameter int IDX_W   = (clog2(NUM_SLV) > 1) ? clog2(NUM_SLV) : 1
) (
    input  logic [ADDR_W-1:0] paddr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              hit_o
);

    assign idx_o = paddr_i[SLV_AW +: IDX_W];
    assign hit_o = ({1'b0, idx_o} < (IDX_W + 1)'(NUM_SLV)) && ((paddr_i >> (SLV_AW + IDX_W)) == '0);

endmodule

// File: rtl/apb_splitter.sv
// apb_splitter: APB 1-to-NUM_SLV fan-out bridge; APB_SPLIT_TIMEOUT_EN adds an ACCESS-phase timeout
module apb_splitter
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int SLV_AW      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      s_psel,
    input  logic                      s_penable,
    input  logic                      s_pwrite,
    input  logic [ADDR_W-1:0]         s_paddr,
    input  logic [APB_PROT_W-1:0]     s_pprot,
    input  logic [DATA_W/8-1:0]       s_pstrb,
    input  logic [DATA_W-1:0]         s_pwdata,
    output logic                      s_pready,
    output logic [DATA_W-1:0]         s_prdata,
    output logic                      s_pslverr,
    output logic [NUM_SLV-1:0]        m_psel,
    output logic                      m_penable,
    output logic                      m_pwrite,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic [APB_PROT_W-1:0]     m_pprot,
    output logic [DATA_W/8-1:0]       m_pstrb,
    output logic [DATA_W-1:0]         m_pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] m_prdata,
    input  logic [NUM_SLV-1:0]        m_pready,
    input  logic [NUM_SLV-1:0]        m_pslverr
);

    localparam int IDX_W = (clog2(NUM_SLV) > 1) ? clog2(NUM_SLV) : 1;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, dec_idx;
    logic                  dec_hit;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [APB_PROT_W-1:0] pprot_q, pprot_d;
    logic [DATA_W/8-1:0]   pstrb_q, pstrb_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
`ifdef APB_SPLIT_TIMEOUT_EN
    logic [15:0]           cnt_q, cnt_d;
`endif

    apb_addr_decode #(
        .ADDR_W (ADDR_W),
        .NUM_SLV(NUM_SLV),
        .SLV_AW (SLV_AW),
        .IDX_W  (IDX_W)
    ) u_dec (
        .paddr_i(s_paddr),
        .idx_o  (dec_idx),
        .hit_o  (dec_hit)
    );

    // next-state: capture on upstream setup, relaunch downstream, latch response
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pprot_d  = pprot_q;
        pstrb_d  = pstrb_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef APB_SPLIT_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: if (s_psel && !s_penable) begin
                idx_d    = dec_idx;
                pwrite_d = s_pwrite;
                paddr_d  = s_paddr;
                pprot_d  = s_pprot;
                pstrb_d  = s_pstrb;
                pwdata_d = s_pwdata;
                rdata_d  = '0;
                err_d    = !dec_hit;
                state_d  = dec_hit ? ST_SETUP : ST_RESP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_SPLIT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_ACCESS: if (m_pready[idx_q]) begin
                rdata_d = pwrite_q ? '0 : m_prdata[idx_q*DATA_W +: DATA_W];
                err_d   = m_pslverr[idx_q];
                state_d = ST_RESP;
            end
`ifdef APB_SPLIT_TIMEOUT_EN
            else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = ST_RESP;
            end else begin
                cnt_d   = cnt_q + 16'd1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // state and captured payload/response registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pprot_q  <= '0;
            pstrb_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef APB_SPLIT_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pprot_q  <= pprot_d;
            pstrb_q  <= pstrb_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef APB_SPLIT_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign m_psel    = (state_q == ST_SETUP || state_q == ST_ACCESS) ? (NUM_SLV'(1) << idx_q) : '0;
    assign m_penable = state_q == ST_ACCESS;
    assign m_pwrite  = pwrite_q;
    assign m_paddr   = paddr_q;
    assign m_pprot   = pprot_q;
    assign m_pstrb   = pstrb_q;
    assign m_pwdata  = pwdata_q;
    assign s_pready  = state_q == ST_RESP;
    assign s_prdata  = s_pready ? rdata_q : '0;
    assign s_pslverr = s_pready && err_q;

endmodule

// File: tb/tb_apb_splitter.sv
// tb_apb_splitter: randomized scoreboard bench for apb_splitter (honours APB_SPLIT_TIMEOUT_EN)
module tb_apb_splitter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int NS  = 4;
    localparam int SAW = 8;
    localparam int TO  = 8;

    logic             pclk = 1'b0;
    logic             preset;
    logic             s_psel, s_penable, s_pwrite;
    logic [AW-1:0]    s_paddr;
    logic [2:0]       s_pprot;
    logic [DW/8-1:0]  s_pstrb;
    logic [DW-1:0]    s_pwdata;
    logic             s_pready;
    logic [DW-1:0]    s_prdata;
    logic             s_pslverr;
    logic [NS-1:0]    m_psel;
    logic             m_penable, m_pwrite;
    logic [AW-1:0]    m_paddr;
    logic [2:0]       m_pprot;
    logic [DW/8-1:0]  m_pstrb;
    logic [DW-1:0]    m_pwdata;
    logic [NS*DW-1:0] m_prdata;
    logic [NS-1:0]    m_pready;
    logic [NS-1:0]    m_pslverr;

    apb_splitter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SLV_AW(SAW), .TIMEOUT_CYC(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pprot(s_pprot), .s_pstrb(s_pstrb), .s_pwdata(s_pwdata),
        .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pprot(m_pprot), .m_pstrb(m_pstrb), .m_pwdata(m_pwdata),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            at;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int            p_slot = -1;
    int            p_wait = 0;
    logic          p_err = 1'b0;
    int            acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every upstream response
    always @(negedge pclk) begin
        if (preset === 1'b0) begin
            if (s_pready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got s_pready=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("s_prdata", s_prdata, e.rdata);
                    chk("s_pslverr", s_pslverr, e.err);
                    chk("resp_cycle", cyc, e.at);
                end
            end else begin
                chk("idle_resp_zero", {s_prdata, s_pslverr}, 0);
            end
        end
    end

    // peripheral model: planned slot answers after p_wait ACCESS cycles, others babble
    always @(negedge pclk) begin
        for (int k = 0; k < NS; k++) begin
            m_pready[k]  = 1'($urandom);
            m_pslverr[k] = 1'($urandom);
        end
        if (p_slot >= 0) begin
            if (m_psel[p_slot] && m_penable) begin
                m_pready[p_slot]  = (acc == p_wait);
                m_pslverr[p_slot] = p_err;
                acc++;
            end else begin
                m_pready[p_slot] = 1'b0;
                acc = 0;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_psel"}, m_psel, 0);
        chk({tag, "_m_penable"}, m_penable, 0);
        chk({tag, "_m_payload"}, {m_pwrite, m_paddr, m_pprot, m_pstrb}, 0);
        chk({tag, "_m_pwdata"}, m_pwdata, 0);
        chk({tag, "_s_resp"}, {s_pready, s_pslverr, s_prdata}, 0);
    endtask

    // one upstream transfer; called at a negedge with the bridge idle
    task automatic xfer(input logic [AW-1:0] a, input logic w, input int wt,
                        input logic [DW-1:0] rd, input logic er, input bit expire);
        bit   hit;
        int   slot, issue, n, budget;
        logic [2:0]      prot;
        logic [DW/8-1:0] strb;
        logic [DW-1:0]   wd;
        hit  = int'(a) < NS * (1 << SAW);
        slot = int'(a) / (1 << SAW);
        prot = 3'($urandom);
        strb = (DW/8)'($urandom);
        wd   = $urandom;
        for (int k = 0; k < NS; k++) m_prdata[k*DW +: DW] = $urandom;
        if (hit) m_prdata[slot*DW +: DW] = rd;
        p_slot = hit ? slot : -1;
        p_wait = wt;
        p_err  = er;
        issue  = cyc + 1;
        if (!hit)
            sb.push_back('{rdata: '0, err: 1'b1, at: issue});
        else if (expire)
            sb.push_back('{rdata: '0, err: 1'b1, at: issue + 1 + TO});
        else
            sb.push_back('{rdata: w ? '0 : rd, err: er, at: issue + 2 + wt});
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = w;
        s_paddr = a; s_pprot = prot; s_pstrb = strb; s_pwdata = wd;
        @(negedge pclk);
        chk("setup_m_psel", m_psel, hit ? (NS'(1) << slot) : 0);
        chk("setup_m_penable", m_penable, 0);
        if (hit) begin
            chk("m_paddr", m_paddr, a);
            chk("m_pwrite", m_pwrite, w);
            chk("m_pwdata", m_pwdata, wd);
            chk("m_pstrb_pprot", {m_pstrb, m_pprot}, {strb, prot});
        end
        s_penable = 1'b1;
        budget = (wt > 1000 ? 1000 : wt) + 20;
        n = 0;
        while (!s_pready && n < budget) begin
            @(negedge pclk);
            n++;
            if (!s_pready) begin
                chk("access_m_penable", m_penable, 1);
                chk("access_m_psel", m_psel, NS'(1) << slot);
            end
        end
        if (s_pready) chk("resp_m_sel_en", {m_psel, m_penable}, 0);
        else chk("resp_within_budget", s_pready, 1);
        s_psel = 1'b0; s_penable = 1'b0;
        @(negedge pclk);
        p_slot = -1;
    endtask

    initial begin
        preset = 1'b1;
        s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        s_paddr = '0; s_pprot = '0; s_pstrb = '0; s_pwdata = '0;
        m_prdata = '0;
        repeat (3) @(negedge pclk);
        chk_all_zero("reset");
        preset = 1'b0;
        @(negedge pclk);

        xfer(12'h104, 1'b1, 0, 32'h0, 1'b0, 1'b0);
        xfer(12'h3F0, 1'b0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
        xfer(12'h800, 1'b0, 0, 32'h12345678, 1'b0, 1'b0);
        xfer(12'h200, 1'b1, 1, 32'h0, 1'b1, 1'b0);
        xfer(12'h000, 1'b1, 0, 32'h0, 1'b0, 1'b0);
        xfer(12'h0FF, 1'b0, 2, 32'hA5A5_0001, 1'b1, 1'b0);
        xfer(12'h400, 1'b1, 0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, NS * (1 << SAW) - 1))
                                            : AW'($urandom_range(0, (1 << AW) - 1));
            xfer(a, 1'($urandom), $urandom_range(0, 4), $urandom, 1'($urandom_range(0, 3) == 0), 1'b0);
        end

`ifdef APB_SPLIT_TIMEOUT_EN
        xfer(12'h010, 1'b0, 100000, 32'hCAFE_F00D, 1'b0, 1'b1);
        xfer(12'h020, 1'b0, TO - 1, 32'h0BAD_CAFE, 1'b0, 1'b0);
`else
        p_slot = 0; p_wait = 100000; p_err = 1'b0;
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 12'h010;
        @(negedge pclk);
        s_penable = 1'b1;
        repeat (1000) @(negedge pclk);
        chk("hang_m_penable", m_penable, 1);
        chk("hang_m_psel", m_psel, 4'b0001);
        chk("hang_s_pready", s_pready, 0);
        preset = 1'b1;
        s_psel = 1'b0; s_penable = 1'b0;
        @(negedge pclk);
        chk_all_zero("hang_reset");
        preset = 1'b0;
        p_slot = -1;
        @(negedge pclk);
`endif

        p_slot = 1; p_wait = 100; p_err = 1'b0;
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b1; s_paddr = 12'h1A0;
        s_pwdata = 32'h5555_AAAA; s_pstrb = 4'hF; s_pprot = 3'b101;
        @(negedge pclk);
        s_penable = 1'b1;
        repeat (2) @(negedge pclk);
        chk("pre_reset_m_penable", m_penable, 1);
        preset = 1'b1;
        s_psel = 1'b0; s_penable = 1'b0;
        @(negedge pclk);
        chk_all_zero("access_reset");
        preset = 1'b0;
        p_slot = -1;
        @(negedge pclk);
        xfer(12'h2C4, 1'b0, 1, 32'h600D_D00D, 1'b0, 1'b0);

        repeat (5) @(negedge pclk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
